// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_if
// Purpose  : Handshake and operand/result bundle between the CPU control unit
//            (master) and the sequential divide controller (slave).
// Signals  : start, signed_op, dividend, divisor      master -> slave
//            busy, done, div_by_zero, quotient,
//            remainder                                slave -> master
// Revision : 1.0  initial release
// ============================================================================
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl
// Purpose  : Multi-cycle divider for the DIV instruction. Runs a one-bit-per-
//            cycle non-restoring division on operand magnitudes over WIDTH
//            iterations, then restores the remainder and applies signs.
//            A zero divisor short-circuits straight to DONE.
// Ports    : clock  - system clock, rising edge
//            clear  - synchronous active-high reset
//            bus    - div_seq_ctrl_if.slave (start/busy/done handshake,
//                     operands in, quotient/remainder/div_by_zero out)
// Revision : 1.0  initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  wire logic     clock,
    input  wire logic     clear,
    div_seq_ctrl_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH:0]     p_q,         p_d;          // signed partial remainder
    logic [WIDTH-1:0]   q_q,         q_d;          // quotient bits being built
    logic [WIDTH-1:0]   d_q,         d_d;          // |divisor|
    logic [c_cnt_w-1:0] count_q,     count_d;
    logic               q_neg_q,     q_neg_d;
    logic               r_neg_q,     r_neg_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;

    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic [WIDTH:0]     w_shift_p;
    logic [WIDTH:0]     w_iter_p;
    logic [WIDTH-1:0]   w_fix_lo;

    // Magnitudes: only negate when the operation is signed and the MSB is set,
    // so unsigned operands with MSB set pass through untouched.
    assign w_dvd_abs = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_dvs_abs = (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // One non-restoring step: shift {P,Q} left, then add or subtract the
    // divisor depending on the sign P had before the shift.
    assign w_shift_p = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign w_iter_p  = p_q[WIDTH] ? (w_shift_p + {1'b0, d_q}) : (w_shift_p - {1'b0, d_q});

    // Final restore; only the low WIDTH bits are needed, so the add is done
    // at WIDTH bits (the result is non-negative after restore).
    assign w_fix_lo  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        d_d         = d_q;
        count_d     = count_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        d_d     = w_dvs_abs;
                        q_d     = w_dvd_abs;
                        p_d     = '0;
                        count_d = '0;
                        q_neg_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_d = bus.signed_op & bus.dividend[WIDTH-1];
                        dbz_d   = 1'b0;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                p_d     = w_iter_p;
                q_d     = {q_q[WIDTH-2:0], ~w_iter_p[WIDTH]};
                count_d = count_q + 1'b1;
                if (count_q == c_last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                p_d         = {1'b0, w_fix_lo};
                quotient_d  = q_neg_q ? -q_q : q_q;
                remainder_d = r_neg_q ? -w_fix_lo : w_fix_lo;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            count_q     <= count_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq_ctrl
// Purpose  : Self-checking bench for div_seq_ctrl. Directed scenarios plus
//            randomized back-to-back divides checked against an arithmetic
//            reference model (64-bit / and %).
// Revision : 1.0  initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference: truncating division on 64-bit values, low W bits kept.
    function automatic void model(input bit sop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z, output int lat);
        longint x;
        longint y;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
        end else begin
            x = sop ? longint'($signed(a)) : longint'({32'd0, a});
            y = sop ? longint'($signed(b)) : longint'({32'd0, b});
            q = 32'(x / y);
            r = 32'(x % y);
            z = 1'b0;
            lat = 34;
        end
    endfunction

    // Issue one divide and wait (bounded) for done; lat=0 means no done seen.
    task automatic run_div(input bit sop, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic z,
                           output int lat, output int busy_cycles);
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = sop; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.signed_op = 1'($urandom); bus.dividend = $urandom; bus.divisor = $urandom;
        lat = 0; busy_cycles = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        clear = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; logic z; int lat, bc;
        run_div(1'b0, 32'd100, 32'd7, q, r, z, lat, bc);
        tests++;
        if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
            fails++;
            $display("FAIL unsigned_100_7: q=%0d r=%0d z=%b, want q=14 r=2 z=0", q, r, z);
        end
        tests++;
        if (lat !== 34) begin
            fails++;
            $display("FAIL unsigned_latency: got %0d cycles, want 34", lat);
        end
        tests++;
        if (bc !== 34) begin
            fails++;
            $display("FAIL unsigned_busy_cycles: got %0d, want 34", bc);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            fails++;
            $display("FAIL unsigned_hold: done=%b busy=%b q=%0d r=%0d, want 0 0 14 2",
                     bus.done, bus.busy, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_signed();
        logic [31:0] a_t [3] = '{-32'sd100, 32'sd100, -32'sd100};
        logic [31:0] b_t [3] = '{32'sd7, -32'sd7, -32'sd7};
        logic [31:0] q_t [3] = '{-32'sd14, -32'sd14, 32'sd14};
        logic [31:0] r_t [3] = '{-32'sd2, 32'sd2, -32'sd2};
        logic [31:0] q, r; logic z; int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_div(1'b1, a_t[i], b_t[i], q, r, z, lat, bc);
            tests++;
            if (q !== q_t[i] || r !== r_t[i] || lat !== 34) begin
                fails++;
                $display("FAIL signed_%0d: q=%h r=%h lat=%0d, want q=%h r=%h lat=34",
                         i, q, r, lat, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_corners();
        bit          s_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] a_t [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        logic [31:0] b_t [4] = '{32'hFFFF_FFFF, 32'd1, 32'd9, 32'hFFFF_FFFF};
        logic [31:0] q_t [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] r_t [4] = '{32'd0, 32'd0, 32'd5, 32'h8000_0000};
        logic [31:0] q, r; logic z; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_div(s_t[i], a_t[i], b_t[i], q, r, z, lat, bc);
            tests++;
            if (q !== q_t[i] || r !== r_t[i] || z !== 1'b0) begin
                fails++;
                $display("FAIL corner_%0d: q=%h r=%h z=%b, want q=%h r=%h z=0",
                         i, q, r, z, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic z; int lat, bc;
        run_div(1'b0, 32'h1234, 32'd0, q, r, z, lat, bc);
        tests++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || z !== 1'b1 || lat !== 1) begin
            fails++;
            $display("FAIL div_zero: q=%h r=%h z=%b lat=%0d, want q=ffffffff r=1234 z=1 lat=1",
                     q, r, z, lat);
        end
        run_div(1'b0, 32'd20, 32'd4, q, r, z, lat, bc);
        tests++;
        if (q !== 32'd5 || r !== 32'd0 || z !== 1'b0) begin
            fails++;
            $display("FAIL after_div_zero: q=%0d r=%0d z=%b, want q=5 r=0 z=0", q, r, z);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 5) begin
                bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (bus.quotient !== 32'd333 || bus.remainder !== 32'd1 || lat !== 34) begin
            fails++;
            $display("FAIL ignore_start: q=%0d r=%0d lat=%0d, want q=333 r=1 lat=34",
                     bus.quotient, bus.remainder, lat);
        end
        // The ignored start must not have launched a second divide.
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_idle: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_clear_mid();
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 ||
            bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL clear_mid: busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL clear_no_done: %0d cycles with done/busy after clear, want 0", seen);
        end
    endtask

    task automatic test_held_start();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = n; break; end
        end
        tests++;
        if (bus.quotient !== 32'd10 || bus.remainder !== 32'd0 || lat == 0) begin
            fails++;
            $display("FAIL held_first: q=%0d r=%0d lat=%0d, want q=10 r=0", bus.quotient, bus.remainder, lat);
        end
        bus.dividend = 32'd81; bus.divisor = 32'd9;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = n; break; end
        end
        bus.start = 1'b0;
        tests++;
        if (bus.quotient !== 32'd9 || bus.remainder !== 32'd0 || lat == 0) begin
            fails++;
            $display("FAIL held_second: q=%0d r=%0d lat=%0d, want q=9 r=0", bus.quotient, bus.remainder, lat);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a, b, q, r, eq, er;
        logic z, ez;
        int lat, elat, bc;
        bit sop;
        for (int i = 0; i < 1500; i++) begin
            sop = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = -$urandom_range(1, 16);
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            model(sop, a, b, eq, er, ez, elat);
            run_div(sop, a, b, q, r, z, lat, bc);
            tests++;
            if (q !== eq || r !== er || z !== ez || lat !== elat) begin
                fails++;
                $display("FAIL random_%0d: s=%b a=%h b=%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         i, sop, a, b, q, r, z, lat, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_corners();
        test_div_zero();
        test_ignore_start();
        test_clear_mid();
        test_held_start();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
